pw_mem_ctrl: RTL and testbench

//  Parametrised password-gated memory controller, successor to the keypad lock + memory path.

---
 rtl/pw_mem_pkg.sv | 29 ++
 rtl/pw_mem_ram.sv | 33 +++
 rtl/pw_mem_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_pw_mem_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pw_mem_pkg.sv
// Shared types and helpers for the password-gated memory controller.
// No latency or backpressure of its own; types and constant functions only.
package pw_mem_pkg;

    typedef enum logic [2:0] {
        LOCKED,
        CHECK,
        UNLOCKED,
        CHPW,
        LOCKOUT
    } state_e;

    localparam int NIBBLE_W = 4;

    // Bits needed to hold values 0..v-1.
    function automatic int clog2(input longint unsigned v);
        int r;
        r = 0;
        while ((64'd1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

    function automatic bit nibble_aligned(input int w);
        return (w > 0) && ((w % NIBBLE_W) == 0);
    endfunction

endpackage

// File: rtl/pw_mem_ram.sv
// Single-port synchronous RAM, write-first, registered read: 1-cycle latency.
// No backpressure; one access per enabled cycle, contents are never reset.
module pw_mem_ram
    import pw_mem_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
                rdata_q       <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pw_mem_ctrl.sv
// Keypad password lock with lockout, idle relock and password change, gating a small RAM.
// Reads return one cycle after commit; no backpressure, every key/commit pulse is acted on or dropped.
module pw_mem_ctrl
    import pw_mem_pkg::*;
#(
    parameter int                     PW_DIGITS   = 4,
    parameter logic [PW_DIGITS*4-1:0] PW_INIT     = 16'h1234,
    parameter int                     ADDR_W      = 4,
    parameter int                     DATA_W      = 8,
    parameter int                     MAX_FAIL    = 3,
    parameter int                     LOCKOUT_CYC = 50_000_000,
    parameter int                     IDLE_CYC    = 500_000_000
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [3:0]                        key_i,
    input  logic                              key_valid_i,
    input  logic                              addr_data_i,
    input  logic                              rd_wr_i,
    input  logic                              commit_i,
    input  logic                              relock_i,
    input  logic                              chpw_i,
    output logic                              locked_o,
    output logic                              unlocked_o,
    output logic                              lockout_o,
    output logic [clog2(MAX_FAIL+1)-1:0]      fail_cnt_o,
    output logic [ADDR_W-1:0]                 addr_out_o,
    output logic [DATA_W-1:0]                 data_out_o,
    output logic [DATA_W-1:0]                 rd_data_o,
    output logic                              rd_valid_o
);

    localparam int  PW_W      = PW_DIGITS * 4;
    localparam int  FC_W      = clog2(MAX_FAIL + 1);
    localparam int  DC_W      = clog2(PW_DIGITS + 1);
    localparam int  LO_W      = clog2(LOCKOUT_CYC + 1);
    localparam int  IDLE_W    = clog2(IDLE_CYC + 1);
    localparam bit  WIDTHS_OK = nibble_aligned(ADDR_W) && nibble_aligned(DATA_W);

    if (!WIDTHS_OK) begin : g_width_chk
        $error("ADDR_W and DATA_W must be non-zero multiples of 4");
    end

    state_e              state_q, state_d;
    logic [PW_W-1:0]     pw_q, pw_d, entry_q, entry_d;
    logic [DC_W-1:0]     dcnt_q, dcnt_d;
    logic [FC_W-1:0]     fail_q, fail_d, fail_inc;
    logic [LO_W-1:0]     lo_q, lo_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d, rd_data_q, rd_data_d, ram_rdata;
    logic                rd_valid_q, rd_valid_d, chpw_q;
    logic                ram_en, ram_we, last_digit, activity, do_relock;

    assign last_digit = (dcnt_q == DC_W'(PW_DIGITS - 1));
    assign fail_inc   = (fail_q == FC_W'(MAX_FAIL)) ? fail_q : fail_q + FC_W'(1);
    assign activity   = key_valid_i || commit_i;
    // A key or commit in the timeout cycle keeps the session alive.
    assign do_relock  = relock_i || ((idle_q == IDLE_W'(IDLE_CYC - 1)) && !activity);

    always_comb begin
        state_d    = state_q;
        pw_d       = pw_q;
        entry_d    = entry_q;
        dcnt_d     = dcnt_q;
        fail_d     = fail_q;
        lo_d       = '0;
        idle_d     = '0;
        addr_d     = addr_q;
        data_d     = data_q;
        rd_data_d  = rd_valid_q ? ram_rdata : rd_data_q;
        rd_valid_d = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        unique case (state_q)
            LOCKED: begin
                if (key_valid_i) begin
                    entry_d = PW_W'({entry_q, key_i});
                    dcnt_d  = dcnt_q + DC_W'(1);
                    if (last_digit) state_d = CHECK;
                end
            end
            CHECK: begin
                entry_d = '0;
                dcnt_d  = '0;
                if (entry_q == pw_q) begin
                    state_d = UNLOCKED;
                    fail_d  = '0;
                end else begin
                    fail_d  = fail_inc;
                    state_d = (fail_inc == FC_W'(MAX_FAIL)) ? LOCKOUT : LOCKED;
                end
            end
            LOCKOUT: begin
                if (lo_q == LO_W'(LOCKOUT_CYC - 1)) begin
                    state_d = LOCKED;
                    fail_d  = '0;
                end else begin
                    lo_d = lo_q + LO_W'(1);
                end
            end
            UNLOCKED: begin
                if (do_relock) begin
                    state_d   = LOCKED;
                    addr_d    = '0;
                    data_d    = '0;
                    rd_data_d = '0;
                end else begin
                    idle_d = activity ? '0 : idle_q + IDLE_W'(1);
                    // The RAM sees the registered buffers, so a same-cycle key lands after the access.
                    if (commit_i) begin
                        ram_en     = 1'b1;
                        ram_we     = rd_wr_i;
                        rd_valid_d = !rd_wr_i;
                    end
                    if (key_valid_i) begin
                        if (addr_data_i) addr_d = ADDR_W'({addr_q, key_i});
                        else             data_d = DATA_W'({data_q, key_i});
                    end
                    if (chpw_i && !chpw_q) state_d = CHPW;
                end
            end
            CHPW: begin
                if (do_relock) begin
                    state_d   = LOCKED;
                    entry_d   = '0;
                    dcnt_d    = '0;
                    addr_d    = '0;
                    data_d    = '0;
                    rd_data_d = '0;
                end else begin
                    idle_d = activity ? '0 : idle_q + IDLE_W'(1);
                    if (key_valid_i) begin
                        entry_d = PW_W'({entry_q, key_i});
                        dcnt_d  = dcnt_q + DC_W'(1);
                        if (last_digit) begin
                            pw_d    = PW_W'({entry_q, key_i});
                            entry_d = '0;
                            dcnt_d  = '0;
                            state_d = UNLOCKED;
                        end
                    end else if (!chpw_i) begin
                        entry_d = '0;
                        dcnt_d  = '0;
                        state_d = UNLOCKED;
                    end
                end
            end
            default: state_d = LOCKED;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= LOCKED;
            pw_q       <= PW_INIT;
            entry_q    <= '0;
            dcnt_q     <= '0;
            fail_q     <= '0;
            lo_q       <= '0;
            idle_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            chpw_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pw_q       <= pw_d;
            entry_q    <= entry_d;
            dcnt_q     <= dcnt_d;
            fail_q     <= fail_d;
            lo_q       <= lo_d;
            idle_q     <= idle_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            chpw_q     <= chpw_i;
        end
    end

    pw_mem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk_i   (clk_i),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (addr_q),
        .wdata_i (data_q),
        .rdata_o (ram_rdata)
    );

    assign locked_o   = (state_q == LOCKED) || (state_q == CHECK);
    assign unlocked_o = (state_q == UNLOCKED) || (state_q == CHPW);
    assign lockout_o  = (state_q == LOCKOUT);
    assign fail_cnt_o = fail_q;
    assign addr_out_o = addr_q;
    assign data_out_o = data_q;
    assign rd_data_o  = rd_valid_q ? ram_rdata : rd_data_q;
    assign rd_valid_o = rd_valid_q;

endmodule

// File: tb/tb_pw_mem_ctrl.sv
// Directed bench for pw_mem_ctrl with shortened lockout (20) and idle (30) timers.
module tb_pw_mem_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key = 4'h0;
    logic       key_valid = 1'b0, addr_data = 1'b0, rd_wr = 1'b0;
    logic       commit = 1'b0, relock = 1'b0, chpw = 1'b0;
    logic       locked, unlocked, lockout, rd_valid;
    logic [1:0] fail_cnt;
    logic [3:0] addr_out;
    logic [7:0] data_out, rd_data;

    int checks = 0;
    int errors = 0;
    int lo_cycles;

    always #5 clk = ~clk;

    pw_mem_ctrl #(
        .PW_DIGITS   (4),
        .PW_INIT     (16'h1234),
        .ADDR_W      (4),
        .DATA_W      (8),
        .MAX_FAIL    (3),
        .LOCKOUT_CYC (20),
        .IDLE_CYC    (30)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .key_i       (key),
        .key_valid_i (key_valid),
        .addr_data_i (addr_data),
        .rd_wr_i     (rd_wr),
        .commit_i    (commit),
        .relock_i    (relock),
        .chpw_i      (chpw),
        .locked_o    (locked),
        .unlocked_o  (unlocked),
        .lockout_o   (lockout),
        .fail_cnt_o  (fail_cnt),
        .addr_out_o  (addr_out),
        .data_out_o  (data_out),
        .rd_data_o   (rd_data),
        .rd_valid_o  (rd_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key = k;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
    endtask

    task automatic enter4(input logic [15:0] code);
        for (int i = 3; i >= 0; i--) press(code[4*i +: 4]);
    endtask

    task automatic pulse_relock();
        relock = 1'b1;
        step();
        relock = 1'b0;
    endtask

    task automatic do_commit(input logic wr);
        rd_wr = wr;
        commit = 1'b1;
        step();
        commit = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_locked"},   locked,   1);
        chk({tag, "_unlocked"}, unlocked, 0);
        chk({tag, "_lockout"},  lockout,  0);
        chk({tag, "_fail"},     fail_cnt, 0);
        chk({tag, "_addr"},     addr_out, 0);
        chk({tag, "_data"},     data_out, 0);
        chk({tag, "_rdata"},    rd_data,  0);
        chk({tag, "_rvld"},     rd_valid, 0);
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        chk_reset_state("rst");

        // Correct password: one CHECK cycle, then unlocked.
        enter4(16'h1234);
        chk("check_locked", locked, 1);
        chk("check_unlocked", unlocked, 0);
        step();
        chk("unlock", unlocked, 1);
        chk("unlock_fail", fail_cnt, 0);
        pulse_relock();
        chk("relock", locked, 1);

        // Three wrong entries lead to lockout.
        enter4(16'h9999);
        step();
        chk("fail1", fail_cnt, 1);
        chk("fail1_locked", locked, 1);
        enter4(16'h9999);
        step();
        chk("fail2", fail_cnt, 2);
        enter4(16'h9999);
        step();
        chk("lockout_on", lockout, 1);
        chk("fail3_sat", fail_cnt, 3);
        lo_cycles = 1;
        while (lo_cycles < 100) begin
            key = 4'h1;
            key_valid = 1'b1;
            step();
            if (!lockout) break;
            lo_cycles++;
        end
        key_valid = 1'b0;
        chk("lockout_len", lo_cycles, 20);
        chk("post_lockout_locked", locked, 1);
        chk("post_lockout_fail", fail_cnt, 0);
        enter4(16'h1234);
        step();
        chk("keys_ignored_in_lockout", unlocked, 1);

        // Buffer assembly, write then read.
        addr_data = 1'b1;
        press(4'h5);
        chk("addr5", addr_out, 4'h5);
        addr_data = 1'b0;
        press(4'hA);
        press(4'h7);
        chk("dataA7", data_out, 8'hA7);
        do_commit(1'b1);
        chk("wr_no_rvld", rd_valid, 0);
        do_commit(1'b0);
        chk("rd_vld", rd_valid, 1);
        chk("rd_data", rd_data, 8'hA7);
        step();
        chk("rd_vld_pulse", rd_valid, 0);
        chk("rd_data_hold", rd_data, 8'hA7);
        // Read with a same-cycle key: access uses the old address.
        addr_data = 1'b1;
        key = 4'h3;
        key_valid = 1'b1;
        rd_wr = 1'b0;
        commit = 1'b1;
        step();
        key_valid = 1'b0;
        commit = 1'b0;
        chk("simul_addr", addr_out, 4'h3);
        chk("simul_rd_data", rd_data, 8'hA7);
        chk("simul_rd_vld", rd_valid, 1);
        pulse_relock();
        chk("relock_addr", addr_out, 0);
        chk("relock_data", data_out, 0);
        chk("relock_rdata", rd_data, 0);

        // Password change, then old fails and new works; aborted change keeps it.
        enter4(16'h1234);
        step();
        chpw = 1'b1;
        step();
        enter4(16'h4321);
        chk("chpw_done_unlocked", unlocked, 1);
        chpw = 1'b0;
        step();
        pulse_relock();
        enter4(16'h1234);
        step();
        chk("old_pw_fail", fail_cnt, 1);
        chk("old_pw_locked", locked, 1);
        enter4(16'h4321);
        step();
        chk("new_pw_unlock", unlocked, 1);
        chk("new_pw_fail_clr", fail_cnt, 0);
        chpw = 1'b1;
        step();
        press(4'h9);
        press(4'h9);
        chpw = 1'b0;
        step();
        chk("abort_unlocked", unlocked, 1);
        pulse_relock();
        enter4(16'h4321);
        step();
        chk("abort_keeps_pw", unlocked, 1);

        // Idle relock; a key in the last idle cycle restarts the count.
        addr_data = 1'b1;
        press(4'h6);
        repeat (29) step();
        chk("idle29_unlocked", unlocked, 1);
        press(4'h2);
        chk("idle_key_wins", unlocked, 1);
        chk("idle_key_addr", addr_out, 4'h2);
        repeat (29) step();
        chk("idle_restart", unlocked, 1);
        step();
        chk("idle_relock", locked, 1);
        chk("idle_addr_clr", addr_out, 0);

        // Reset during a password change restores PW_INIT.
        enter4(16'h4321);
        step();
        chpw = 1'b1;
        step();
        enter4(16'h5678);
        chpw = 1'b0;
        step();
        chpw = 1'b1;
        step();
        press(4'h1);
        rst = 1'b1;
        chpw = 1'b0;
        step();
        rst = 1'b0;
        chk_reset_state("rst_chpw");
        enter4(16'h1234);
        step();
        chk("pw_init_restored", unlocked, 1);

        // Reset during lockout.
        pulse_relock();
        repeat (3) begin
            enter4(16'h9999);
            step();
        end
        chk("lockout_again", lockout, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_state("rst_lockout");
        enter4(16'h1234);
        step();
        chk("unlock_after_rst", unlocked, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
